// File: rtl/mbed_instr_rx.sv
// Serial instruction receiver for the MBED link: synchronized strobe/data,
// MSB-first frame with trailing even parity, held until the controller clears it.
module mbed_instr_rx #(
    parameter int INSTR_W     = 10,
    parameter int TIMEOUT_CYC = 2500000,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               data_in,
    input  logic               confirm_in,
    input  logic               clear,
    output logic [INSTR_W-1:0] instr,
    output logic               ready,
    output logic               busy,
    output logic               parity_err,
    output logic               timeout
);

    localparam int CNT_W   = $clog2(INSTR_W + 2);
    localparam int TCNT_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int PRIME_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [SYNC_STAGES-1:0] data_sync_reg;
    logic [SYNC_STAGES-1:0] conf_sync_reg;
    logic                   conf_prev_reg;
    logic [PRIME_W-1:0]     prime_cnt_reg;
    logic                   data_s;
    logic                   conf_s;
    logic                   primed;
    logic                   confirm_edge;

    logic [INSTR_W:0]       shift_reg;
    logic [CNT_W-1:0]       bit_cnt_reg;
    logic [TCNT_W-1:0]      tcnt_reg;
    logic [INSTR_W-1:0]     instr_reg;
    logic                   ready_reg;
    logic                   busy_reg;
    logic                   parity_err_reg;
    logic                   timeout_reg;

    logic                   start_frame;
    logic                   shift_en;
    logic                   load_instr;
    logic                   perr_set;
    logic                   tout_set;
    logic                   parity_ok;

    // Equal-depth synchronizers keep data and strobe aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_sync_reg[0] <= 1'b0;
            conf_sync_reg[0] <= 1'b0;
        end else begin
            data_sync_reg[0] <= data_in;
            conf_sync_reg[0] <= confirm_in;
        end
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (reset) begin
                    data_sync_reg[gi] <= 1'b0;
                    conf_sync_reg[gi] <= 1'b0;
                end else begin
                    data_sync_reg[gi] <= data_sync_reg[gi-1];
                    conf_sync_reg[gi] <= conf_sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign data_s = data_sync_reg[SYNC_STAGES-1];
    assign conf_s = conf_sync_reg[SYNC_STAGES-1];
    assign primed = (prime_cnt_reg == PRIME_W'(SYNC_STAGES));

    // Until the synchronizers have refilled after reset, the previous-level
    // copy is pinned high so a strobe already asserted cannot look like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            prime_cnt_reg <= '0;
            conf_prev_reg <= 1'b1;
        end else if (!primed) begin
            prime_cnt_reg <= prime_cnt_reg + PRIME_W'(1);
            conf_prev_reg <= 1'b1;
        end else begin
            conf_prev_reg <= conf_s;
        end
    end

    assign confirm_edge = primed & conf_s & ~conf_prev_reg;
    assign parity_ok    = ~(^shift_reg);

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        load_instr  = 1'b0;
        perr_set    = 1'b0;
        tout_set    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!clear && enable && confirm_edge) begin
                    start_frame = 1'b1;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                if (clear || !enable) begin
                    state_next = IDLE;
                end else if (confirm_edge) begin
                    shift_en = 1'b1;
                    if (bit_cnt_reg == CNT_W'(INSTR_W)) state_next = CHECK;
                end else if (tcnt_reg == TCNT_W'(TIMEOUT_CYC - 1)) begin
                    tout_set   = 1'b1;
                    state_next = IDLE;
                end
            end
            CHECK: begin
                if (clear) begin
                    state_next = IDLE;
                end else if (parity_ok) begin
                    load_instr = 1'b1;
                    state_next = HOLD;
                end else begin
                    perr_set   = 1'b1;
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (clear) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            tcnt_reg    <= '0;
        end else if (start_frame) begin
            shift_reg   <= {{INSTR_W{1'b0}}, data_s};
            bit_cnt_reg <= CNT_W'(1);
            tcnt_reg    <= '0;
        end else if (shift_en) begin
            shift_reg   <= {shift_reg[INSTR_W-1:0], data_s};
            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
            tcnt_reg    <= '0;
        end else if (state_next == IDLE) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            tcnt_reg    <= '0;
        end else if (state_reg == SHIFT) begin
            tcnt_reg    <= tcnt_reg + TCNT_W'(1);
        end
    end

    // Outputs are registered from the next-state decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_reg      <= '0;
            ready_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            parity_err_reg <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            if (load_instr) instr_reg <= shift_reg[INSTR_W:1];
            ready_reg      <= (state_next == HOLD);
            busy_reg       <= (state_next == SHIFT) || (state_next == CHECK);
            parity_err_reg <= perr_set;
            timeout_reg    <= tout_set;
        end
    end

    assign instr      = instr_reg;
    assign ready      = ready_reg;
    assign busy       = busy_reg;
    assign parity_err = parity_err_reg;
    assign timeout    = timeout_reg;

endmodule

// File: tb/tb_mbed_instr_rx.sv
// Directed bench for mbed_instr_rx: good/bad frames, timeout, hold/clear,
// long strobe, reset mid-frame and enable handling.
module tb_mbed_instr_rx;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b1;
    logic         data_in = 1'b0;
    logic         confirm_in = 1'b0;
    logic         clear = 1'b0;
    logic [W-1:0] instr;
    logic         ready;
    logic         busy;
    logic         parity_err;
    logic         timeout;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [W-1:0] FRAME_A = 10'b1000000101;  // parity 1
    localparam logic [W-1:0] FRAME_B = 10'b0011110000;  // parity 0

    mbed_instr_rx #(
        .INSTR_W    (W),
        .TIMEOUT_CYC(100),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .data_in   (data_in),
        .confirm_in(confirm_in),
        .clear     (clear),
        .instr     (instr),
        .ready     (ready),
        .busy      (busy),
        .parity_err(parity_err),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int hi);
        @(negedge clk);
        data_in = b;
        @(negedge clk);
        confirm_in = 1'b1;
        repeat (hi) @(negedge clk);
        confirm_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic p);
        for (int i = W - 1; i >= 0; i--) send_bit(d[i], 1);
        send_bit(p, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk); #1;
        check1("clear_ready", ready, 1'b0);
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        int k;

        // Reset with the strobe already high must not yield an edge afterwards.
        confirm_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkw("rst_instr", instr, '0);
        check1("rst_ready", ready, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_perr", parity_err, 1'b0);
        check1("rst_tout", timeout, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check1("rst_high_strobe_busy", busy, 1'b0);
        confirm_in = 1'b0;
        repeat (3) @(negedge clk);
        $display("step: reset with strobe high");

        // Good frame with exact latency on the parity edge.
        for (int i = W - 1; i >= 0; i--) send_bit(FRAME_A[i], 1);
        @(negedge clk);
        data_in = 1'b1;
        @(negedge clk);
        confirm_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check1("lat_ready_early", ready, 1'b0);
        check1("lat_busy_check", busy, 1'b1);
        @(posedge clk); #1;
        check1("lat_ready", ready, 1'b1);
        checkw("good_instr", instr, FRAME_A);
        check1("good_perr", parity_err, 1'b0);
        check1("good_busy", busy, 1'b0);
        @(negedge clk);
        confirm_in = 1'b0;
        $display("step: good frame A");

        // Edges in HOLD are ignored.
        repeat (3) send_bit(1'b0, 1);
        checkw("hold_instr", instr, FRAME_A);
        check1("hold_ready", ready, 1'b1);
        check1("hold_busy", busy, 1'b0);
        do_clear();
        $display("step: hold edges and clear");

        send_frame(FRAME_B, 1'b0);
        check1("b_ready", ready, 1'b1);
        checkw("b_instr", instr, FRAME_B);
        do_clear();
        $display("step: good frame B");

        // Bad parity: one-cycle error pulse, instr untouched.
        for (int i = W - 1; i >= 0; i--) send_bit(FRAME_A[i], 1);
        @(negedge clk);
        data_in = 1'b0;
        @(negedge clk);
        confirm_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check1("bad_perr", parity_err, 1'b1);
        check1("bad_ready", ready, 1'b0);
        checkw("bad_instr", instr, FRAME_B);
        @(posedge clk); #1;
        check1("bad_perr_pulse", parity_err, 1'b0);
        check1("bad_busy", busy, 1'b0);
        @(negedge clk);
        confirm_in = 1'b0;
        $display("step: bad parity");

        // Timeout after 4 bits; last edge lands 100 cycles before the pulse.
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1);
        check1("to_busy_before", busy, 1'b1);
        k = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (timeout === 1'b1) begin
                k = c;
                break;
            end
        end
        check1("to_seen", (k == 100), 1'b1);
        check1("to_busy", busy, 1'b0);
        @(posedge clk); #1;
        check1("to_pulse", timeout, 1'b0);
        send_frame(FRAME_A, 1'b1);
        check1("to_after_ready", ready, 1'b1);
        checkw("to_after_instr", instr, FRAME_A);
        do_clear();
        $display("step: timeout then good frame (pulse at cycle %0d)", k);

        // Long strobe on the first bit counts once.
        send_bit(FRAME_B[W-1], 50);
        for (int i = W - 2; i >= 0; i--) send_bit(FRAME_B[i], 1);
        send_bit(1'b0, 1);
        repeat (3) @(negedge clk);
        check1("long_ready", ready, 1'b1);
        checkw("long_instr", instr, FRAME_B);
        do_clear();
        $display("step: long strobe");

        // Reset after 6 bits.
        for (int i = W - 1; i >= W - 6; i--) send_bit(FRAME_A[i], 1);
        check1("rst6_busy_before", busy, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check1("rst6_busy", busy, 1'b0);
        check1("rst6_ready", ready, 1'b0);
        checkw("rst6_instr", instr, '0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        send_frame(FRAME_A, 1'b1);
        check1("rst6_after_ready", ready, 1'b1);
        checkw("rst6_after_instr", instr, FRAME_A);
        do_clear();
        $display("step: reset after 6 bits");

        // Enable drop mid-frame aborts silently; edges with enable low ignored.
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check1("en_abort_busy", busy, 1'b0);
        check1("en_abort_perr", parity_err, 1'b0);
        check1("en_abort_tout", timeout, 1'b0);
        send_bit(1'b1, 1);
        check1("en_low_busy", busy, 1'b0);
        enable = 1'b1;
        send_frame(FRAME_B, 1'b0);
        checkw("en_after_instr", instr, FRAME_B);
        check1("en_after_ready", ready, 1'b1);
        $display("step: enable abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
